regfile_writeback: RTL

//  Writer side of the 32x16 register file write port (enw/rd_add/write_data), located in the WB stage.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_writeback_pending_load_fifo.sv | 60 ++++++
 rtl/regfile_writeback.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, depths and the pending-load entry type for the WB-stage register file writer.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int LD_DEPTH = 4;
    localparam int LD_PTR_W = $clog2(LD_DEPTH);

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
    } ld_entry_t;

endpackage

// File: rtl/regfile_writeback_pending_load_fifo.sv
// In-order queue of outstanding load destinations; every slot is exposed so the
// busy scoreboard can match against all loads still in flight.
module pending_load_fifo
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_rd,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_head_rd,
    output ld_entry_t         o_entries [LD_DEPTH]
);

    ld_entry_t           r_entries [LD_DEPTH];
    logic [LD_PTR_W-1:0] r_wr_ptr;
    logic [LD_PTR_W-1:0] r_rd_ptr;
    logic [LD_PTR_W:0]   r_count;

    logic w_push;
    logic w_pop;

    assign o_full    = (r_count == (LD_PTR_W + 1)'(LD_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head_rd = r_entries[r_rd_ptr].rd;
    assign o_entries = r_entries;

    // Push and pop never target the same slot: push needs !full, pop needs !empty.
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_entries[r_wr_ptr].valid <= 1'b1;
                r_entries[r_wr_ptr].rd    <= i_push_rd;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_entries[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr                  <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// WB-stage writer for the register file port: merges ALU results and in-order load
// returns onto one registered write port, and tracks per-register writes in flight.
module regfile_writeback
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_rd,
    output logic              ld_issue_ready,
    input  logic              ld_resp_valid,
    input  logic [DATA_W-1:0] ld_resp_data,
    input  logic [ADDR_W-1:0] chk_add1,
    input  logic [ADDR_W-1:0] chk_add2,
    output logic              busy1,
    output logic              busy2,
    output logic              enw,
    output logic [ADDR_W-1:0] rd_add,
    output logic [DATA_W-1:0] write_data,
    output logic              err
);

    logic              r_hold_valid;
    logic [ADDR_W-1:0] r_hold_rd;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_enw;
    logic [ADDR_W-1:0] r_rd_add;
    logic [DATA_W-1:0] r_write_data;
    logic              r_err;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [ADDR_W-1:0] w_head_rd;
    ld_entry_t         w_entries [LD_DEPTH];

    logic              w_alu_acc;
    logic              w_pop;
    logic              w_sel_valid;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_hold_load;
    logic              w_hold_clear;
    logic              w_match1;
    logic              w_match2;

    assign alu_ready      = ~r_hold_valid;
    assign ld_issue_ready = ~w_fifo_full;
    assign w_alu_acc      = alu_valid & alu_ready;
    assign w_pop          = ld_resp_valid & ~w_fifo_empty;

    assign enw        = r_enw;
    assign rd_add     = r_rd_add;
    assign write_data = r_write_data;
    assign err        = r_err;

    pending_load_fifo u_pending_load_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (ld_issue),
        .i_push_rd (ld_rd),
        .i_pop     (w_pop),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head_rd (w_head_rd),
        .o_entries (w_entries)
    );

    // A load response owns the port even when orphaned; a concurrent ALU result parks in hold.
    always_comb begin
        w_sel_valid  = 1'b0;
        w_sel_rd     = REG_ZERO;
        w_sel_data   = '0;
        w_hold_load  = 1'b0;
        w_hold_clear = 1'b0;
        if (ld_resp_valid) begin
            w_hold_load = w_alu_acc;
            if (!w_fifo_empty) begin
                w_sel_valid = 1'b1;
                w_sel_rd    = w_head_rd;
                w_sel_data  = ld_resp_data;
            end
        end else if (r_hold_valid) begin
            w_sel_valid  = 1'b1;
            w_sel_rd     = r_hold_rd;
            w_sel_data   = r_hold_data;
            w_hold_clear = 1'b1;
        end else if (w_alu_acc) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = alu_rd;
            w_sel_data  = alu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= 1'b0;
            r_hold_rd    <= '0;
            r_hold_data  <= '0;
        end else if (w_hold_load) begin
            r_hold_valid <= 1'b1;
            r_hold_rd    <= alu_rd;
            r_hold_data  <= alu_data;
        end else if (w_hold_clear) begin
            r_hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enw        <= 1'b0;
            r_rd_add     <= '0;
            r_write_data <= '0;
            r_err        <= 1'b0;
        end else begin
            r_enw <= w_sel_valid & (w_sel_rd != REG_ZERO);
            if (w_sel_valid) begin
                r_rd_add     <= w_sel_rd;
                r_write_data <= w_sel_data;
            end
            if (ld_resp_valid && w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    // The enw term keeps busy up through the cycle the RF actually latches the value.
    always_comb begin
        w_match1 = (r_hold_valid && r_hold_rd == chk_add1) || (r_enw && r_rd_add == chk_add1);
        w_match2 = (r_hold_valid && r_hold_rd == chk_add2) || (r_enw && r_rd_add == chk_add2);
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (w_entries[i].valid && w_entries[i].rd == chk_add1) w_match1 = 1'b1;
            if (w_entries[i].valid && w_entries[i].rd == chk_add2) w_match2 = 1'b1;
        end
        busy1 = w_match1 && (chk_add1 != REG_ZERO);
        busy2 = w_match2 && (chk_add2 != REG_ZERO);
    end

endmodule
